// File: rtl/fetch_redirect_unit_if.sv
// Signal bundle between the fetch redirect unit and its neighbours: jump redirects from
// execute, the imem request/response channel and the two-slot packet channel to decode.
// Handshakes: a transfer happens on a cycle where valid and ready are both high; the
// sender holds valid and its payload stable until that cycle, and ready may depend on valid.
interface fetch_redirect_unit_if;
   logic        way0_jumpFlag_i;
   logic [31:0] way0_jumpAddr_i;
   logic        way1_jumpFlag_i;
   logic [31:0] way1_jumpAddr_i;
   logic        imem_req_valid_o;
   logic        imem_req_ready_i;
   logic [31:0] imem_req_addr_o;
   logic        imem_rsp_valid_i;
   logic [63:0] imem_rsp_data_i;
   logic        fetch_valid_o;
   logic        fetch_ready_i;
   logic        fetch_way0_valid_o;
   logic [31:0] fetch_way0_pc_o;
   logic [31:0] fetch_way0_inst_o;
   logic        fetch_way1_valid_o;
   logic [31:0] fetch_way1_pc_o;
   logic [31:0] fetch_way1_inst_o;
   logic        fetch_flush_o;

   modport slave (
      input  way0_jumpFlag_i, way0_jumpAddr_i, way1_jumpFlag_i, way1_jumpAddr_i,
      input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, fetch_ready_i,
      output imem_req_valid_o, imem_req_addr_o, fetch_valid_o,
      output fetch_way0_valid_o, fetch_way0_pc_o, fetch_way0_inst_o,
      output fetch_way1_valid_o, fetch_way1_pc_o, fetch_way1_inst_o, fetch_flush_o
   );

   modport master (
      output way0_jumpFlag_i, way0_jumpAddr_i, way1_jumpFlag_i, way1_jumpAddr_i,
      output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i, fetch_ready_i,
      input  imem_req_valid_o, imem_req_addr_o, fetch_valid_o,
      input  fetch_way0_valid_o, fetch_way0_pc_o, fetch_way0_inst_o,
      input  fetch_way1_valid_o, fetch_way1_pc_o, fetch_way1_inst_o, fetch_flush_o
   );
endinterface

// File: rtl/fetch_redirect_unit.sv
// Fetch redirect unit: owns the fetch PC, issues 8-byte imem requests, buffers packets for
// decode and restarts fetch on jump redirects. Optional perf counters: FETCH_PERF_CNT_EN.
module fetch_redirect_unit #(
   parameter logic [31:0] RESET_PC        = 32'h8000_0000,
   parameter int          MAX_OUTSTANDING = 2,
   parameter int          BUF_DEPTH       = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   fetch_redirect_unit_if.slave bus
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]          perf_redirect_cnt_o,
   output logic [31:0]          perf_drop_cnt_o
`endif
);
   localparam int TAG_DEPTH = 4;
   localparam int BUF_AW    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int CNT_W     = BUF_AW + 1;
   localparam int SUM_W     = CNT_W + 3;

   logic [28:0]       pc_q;
   logic              skip0_q;
   logic [2:0]        out_q;
   logic [2:0]        drop_q;
   logic [29:0]       tag_mem_q [TAG_DEPTH];
   logic [1:0]        tag_wr_q;
   logic [1:0]        tag_rd_q;
   logic [28:0]       buf_pc_q   [BUF_DEPTH];
   logic              buf_skip_q [BUF_DEPTH];
   logic [63:0]       buf_data_q [BUF_DEPTH];
   logic [BUF_AW-1:0] buf_wr_q;
   logic [BUF_AW-1:0] buf_rd_q;
   logic [CNT_W-1:0]  buf_cnt_q;

   logic              redirect;
   logic [31:2]       target;
   logic              unused_addr_lsbs;
   logic [SUM_W-1:0]  inflight;
   logic              credit_ok;
   logic              req_valid;
   logic              req_fire;
   logic              rsp_fire;
   logic              rsp_keep;
   logic              rsp_discard;
   logic              fetch_valid;
   logic              pop;

   assign redirect         = bus.way0_jumpFlag_i | bus.way1_jumpFlag_i;
   assign target           = bus.way0_jumpFlag_i ? bus.way0_jumpAddr_i[31:2]
                                                 : bus.way1_jumpAddr_i[31:2];
   assign unused_addr_lsbs = ^{bus.way0_jumpAddr_i[1:0], bus.way1_jumpAddr_i[1:0]};

   // Credits cover every packet that may still land in the buffer, including stale
   // responses still in flight, so the buffer can never overflow.
   assign inflight  = SUM_W'(out_q) + SUM_W'(buf_cnt_q);
   assign credit_ok = inflight < SUM_W'(BUF_DEPTH);
   assign req_valid = !rst_i && !redirect && (out_q < 3'(MAX_OUTSTANDING)) && credit_ok;
   assign req_fire  = req_valid && bus.imem_req_ready_i;

   // A response with nothing outstanding (e.g. one requested before reset) is ignored.
   assign rsp_fire    = bus.imem_rsp_valid_i && (out_q != 3'd0);
   assign rsp_discard = rsp_fire && (redirect || (drop_q != 3'd0));
   assign rsp_keep    = rsp_fire && !redirect && (drop_q == 3'd0);

   assign fetch_valid = (buf_cnt_q != '0);
   assign pop         = fetch_valid && bus.fetch_ready_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc_q      <= RESET_PC[31:3];
         skip0_q   <= 1'b0;
         out_q     <= 3'd0;
         drop_q    <= 3'd0;
         tag_wr_q  <= 2'd0;
         tag_rd_q  <= 2'd0;
         buf_wr_q  <= '0;
         buf_rd_q  <= '0;
         buf_cnt_q <= '0;
      end else begin
         if (req_fire && !rsp_fire) begin
            out_q <= out_q + 3'd1;
         end else if (!req_fire && rsp_fire) begin
            out_q <= out_q - 3'd1;
         end
         if (redirect) begin
            pc_q      <= target[31:3];
            skip0_q   <= target[2];
            // Everything still in flight after this edge belongs to the old path.
            drop_q    <= out_q - {2'b00, rsp_fire};
            tag_wr_q  <= 2'd0;
            tag_rd_q  <= 2'd0;
            buf_wr_q  <= '0;
            buf_rd_q  <= '0;
            buf_cnt_q <= '0;
         end else begin
            if (req_fire) begin
               pc_q     <= pc_q + 29'd1;
               skip0_q  <= 1'b0;
               tag_wr_q <= tag_wr_q + 2'd1;
            end
            if (rsp_discard) begin
               drop_q <= drop_q - 3'd1;
            end
            if (rsp_keep) begin
               tag_rd_q <= tag_rd_q + 2'd1;
               buf_wr_q <= buf_wr_q + BUF_AW'(1);
            end
            if (pop) begin
               buf_rd_q <= buf_rd_q + BUF_AW'(1);
            end
            buf_cnt_q <= buf_cnt_q + CNT_W'(rsp_keep) - CNT_W'(pop);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (req_fire) begin
         tag_mem_q[tag_wr_q] <= {pc_q, skip0_q};
      end
      if (rsp_keep) begin
         buf_pc_q[buf_wr_q]   <= tag_mem_q[tag_rd_q][29:1];
         buf_skip_q[buf_wr_q] <= tag_mem_q[tag_rd_q][0];
         buf_data_q[buf_wr_q] <= bus.imem_rsp_data_i;
      end
   end

   assign bus.imem_req_valid_o   = req_valid;
   assign bus.imem_req_addr_o    = {pc_q, 3'b000};
   assign bus.fetch_flush_o      = redirect && !rst_i;
   assign bus.fetch_valid_o      = fetch_valid;
   // Slot data is zeroed while the buffer is empty so idle outputs never show stale entries.
   assign bus.fetch_way0_valid_o = fetch_valid && !buf_skip_q[buf_rd_q];
   assign bus.fetch_way1_valid_o = fetch_valid;
   assign bus.fetch_way0_pc_o    = fetch_valid ? {buf_pc_q[buf_rd_q], 3'b000} : 32'd0;
   assign bus.fetch_way1_pc_o    = fetch_valid ? {buf_pc_q[buf_rd_q], 3'b100} : 32'd0;
   assign bus.fetch_way0_inst_o  = fetch_valid ? buf_data_q[buf_rd_q][31:0] : 32'd0;
   assign bus.fetch_way1_inst_o  = fetch_valid ? buf_data_q[buf_rd_q][63:32] : 32'd0;

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         perf_redirect_cnt_o <= 32'd0;
         perf_drop_cnt_o     <= 32'd0;
      end else begin
         if (redirect) begin
            perf_redirect_cnt_o <= perf_redirect_cnt_o + 32'd1;
         end
         if (rsp_discard) begin
            perf_drop_cnt_o <= perf_drop_cnt_o + 32'd1;
         end
      end
   end
`endif
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: imem model with configurable latency, scoreboard of expected
// decode packets pushed on request acceptance and compared whenever decode sees a packet.
module tb_fetch_redirect_unit;
   localparam logic [31:0] RESET_PC  = 32'h8000_0000;
   localparam int          BUF_DEPTH = 2;
   localparam int          W         = 97;

   logic clk;
   logic rst;
   fetch_redirect_unit_if ifc();

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_redirect_cnt;
   logic [31:0] perf_drop_cnt;
`endif

   fetch_redirect_unit #(
      .RESET_PC(RESET_PC), .MAX_OUTSTANDING(2), .BUF_DEPTH(BUF_DEPTH)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus(ifc)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_redirect_cnt_o(perf_redirect_cnt),
      .perf_drop_cnt_o(perf_drop_cnt)
`endif
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- scoreboard state ----------------
   int          checks;
   int          failures;
   int          cyc;
   int          lat;
   int          n_pops;
   int          n_acc;
   logic [W-1:0] exp_q[$];       // {pc, skip0, data}
   logic [63:0] pend_data[$];
   int          pend_due[$];
   logic [31:0] exp_pc;
   logic        exp_skip;

   logic        s_req_valid, s_flush, s_fvalid, s_w0_valid, s_w1_valid, s_acc, s_pop;
   logic [31:0] s_req_addr, s_acc_addr, s_w0_pc, s_w1_pc, s_w0_inst, s_w1_inst;

   // One cycle: sample at the falling edge, score, then advance and drive the imem response.
   task automatic step();
      logic [W-1:0]  e;
      logic [129:0]  act, req;
      logic [31:0]   tgt;
      @(negedge clk);
      s_req_valid = ifc.imem_req_valid_o;
      s_req_addr  = ifc.imem_req_addr_o;
      s_flush     = ifc.fetch_flush_o;
      s_fvalid    = ifc.fetch_valid_o;
      s_w0_valid  = ifc.fetch_way0_valid_o;
      s_w1_valid  = ifc.fetch_way1_valid_o;
      s_w0_pc     = ifc.fetch_way0_pc_o;
      s_w1_pc     = ifc.fetch_way1_pc_o;
      s_w0_inst   = ifc.fetch_way0_inst_o;
      s_w1_inst   = ifc.fetch_way1_inst_o;
      s_acc       = 1'b0;
      s_pop       = 1'b0;
      if (ifc.fetch_valid_o) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL pkt_unexpected: got pc0=%h inst0=%h, required no packet", s_w0_pc, s_w0_inst);
         end else begin
            e   = exp_q[0];
            act = {s_w0_valid, s_w1_valid, s_w0_pc, s_w1_pc, s_w0_inst, s_w1_inst};
            req = {~e[64], 1'b1, e[96:65], e[96:65] + 32'd4, e[31:0], e[63:32]};
            if (act !== req) begin
               failures++;
               $display("FAIL pkt: got %h, required %h", act, req);
            end
            if (ifc.fetch_ready_i) begin
               void'(exp_q.pop_front());
               n_pops++;
               s_pop = 1'b1;
            end
         end
      end
      if (ifc.imem_req_valid_o && ifc.imem_req_ready_i) begin
         checks++;
         if (ifc.imem_req_addr_o !== exp_pc) begin
            failures++;
            $display("FAIL req_addr: got %h, required %h", ifc.imem_req_addr_o, exp_pc);
         end
         pend_data.push_back({$urandom, $urandom});
         pend_due.push_back(cyc + lat);
         exp_q.push_back({exp_pc, exp_skip, pend_data[pend_data.size() - 1]});
         s_acc      = 1'b1;
         s_acc_addr = ifc.imem_req_addr_o;
         exp_pc     = exp_pc + 32'd8;
         exp_skip   = 1'b0;
         n_acc++;
      end
      if (ifc.way0_jumpFlag_i || ifc.way1_jumpFlag_i) begin
         tgt = ifc.way0_jumpFlag_i ? ifc.way0_jumpAddr_i : ifc.way1_jumpAddr_i;
         checks++;
         if ({s_flush, s_req_valid} !== 2'b10) begin
            failures++;
            $display("FAIL redirect_cycle: flush/req_valid=%b, required 10", {s_flush, s_req_valid});
         end
         exp_q.delete();
         exp_pc   = {tgt[31:3], 3'b000};
         exp_skip = tgt[2];
      end
      if (rst) begin
         exp_q.delete();
         exp_pc   = RESET_PC;
         exp_skip = 1'b0;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
         ifc.imem_rsp_valid_i = 1'b1;
         ifc.imem_rsp_data_i  = pend_data.pop_front();
         void'(pend_due.pop_front());
      end else begin
         ifc.imem_rsp_valid_i = 1'b0;
         ifc.imem_rsp_data_i  = {$urandom, $urandom};
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      step();
      checks++;
      if ({s_req_valid, s_flush, s_fvalid, s_w0_valid, s_w1_valid} !== 5'b0) begin
         failures++;
         $display("FAIL reset_ctrl: got %b, required 00000", {s_req_valid, s_flush, s_fvalid, s_w0_valid, s_w1_valid});
      end
      checks++;
      if (s_req_addr !== RESET_PC) begin
         failures++;
         $display("FAIL reset_addr: got %h, required %h", s_req_addr, RESET_PC);
      end
      checks++;
      if ({s_w0_pc, s_w1_pc, s_w0_inst, s_w1_inst} !== 128'd0) begin
         failures++;
         $display("FAIL reset_data: got %h %h %h %h, required zeros", s_w0_pc, s_w1_pc, s_w0_inst, s_w1_inst);
      end
      ifc.imem_req_ready_i = 1'b1;
      ifc.fetch_ready_i    = 1'b1;
      rst = 1'b0;
   endtask

   task automatic test_sequential();
      int pops0;
      lat   = 1;
      pops0 = n_pops;
      step();
      checks++;
      if (!(s_acc && s_acc_addr == RESET_PC)) begin
         failures++;
         $display("FAIL first_req: acc=%b addr=%h, required 1 %h", s_acc, s_acc_addr, RESET_PC);
      end
      for (int i = 0; i < 24; i++) step();
      checks++;
      if (n_pops - pops0 < 5) begin
         failures++;
         $display("FAIL seq_throughput: got %0d packets, required at least 5", n_pops - pops0);
      end
   endtask

   task automatic test_redirect_drop();
      logic found;
      lat   = 3;
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (pend_data.size() + int'(ifc.imem_rsp_valid_i) >= 2) found = 1'b1;
         else step();
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL drop_setup: got %0d outstanding, required 2", pend_data.size());
      end
      ifc.way0_jumpFlag_i = 1'b1;
      ifc.way0_jumpAddr_i = 32'h8000_0104;
      step();
      ifc.way0_jumpFlag_i = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         step();
         found = s_acc;
      end
      checks++;
      if (!(found && s_acc_addr == 32'h8000_0100)) begin
         failures++;
         $display("FAIL drop_first_req: found=%b addr=%h, required 1 80000100", found, s_acc_addr);
      end
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         step();
         found = s_pop;
      end
      checks++;
      if (!(found && !s_w0_valid && s_w1_pc == 32'h8000_0104)) begin
         failures++;
         $display("FAIL drop_first_pkt: found=%b w0_valid=%b w1_pc=%h, required 1 0 80000104", found, s_w0_valid, s_w1_pc);
      end
   endtask

   task automatic redirect_latency(input logic f0, input logic [31:0] a0,
                                   input logic f1, input logic [31:0] a1,
                                   input logic [31:0] want);
      ifc.way0_jumpFlag_i = f0;
      ifc.way0_jumpAddr_i = a0;
      ifc.way1_jumpFlag_i = f1;
      ifc.way1_jumpAddr_i = a1;
      step();
      ifc.way0_jumpFlag_i = 1'b0;
      ifc.way1_jumpFlag_i = 1'b0;
      step();
      checks++;
      if (!(s_acc && s_acc_addr == want)) begin
         failures++;
         $display("FAIL redirect_req: acc=%b addr=%h, required 1 %h", s_acc, s_acc_addr, want);
      end
      step();
      checks++;
      if (s_fvalid !== 1'b0) begin
         failures++;
         $display("FAIL redirect_early_pkt: fetch_valid=%b, required 0", s_fvalid);
      end
      step();
      checks++;
      if (!(s_fvalid && s_w0_pc == want)) begin
         failures++;
         $display("FAIL redirect_pkt_latency: valid=%b pc0=%h, required 1 %h", s_fvalid, s_w0_pc, want);
      end
   endtask

   task automatic test_both_flags();
      lat = 1;
      for (int i = 0; i < 8; i++) step();
      redirect_latency(1'b1, 32'h0000_0200, 1'b1, 32'h0000_0300, 32'h0000_0200);
      for (int i = 0; i < 4; i++) step();
      redirect_latency(1'b0, 32'h0000_0400, 1'b1, 32'h0000_0300, 32'h0000_0300);
   endtask

   task automatic test_stall();
      int acc0, pops0;
      ifc.fetch_ready_i = 1'b0;
      acc0 = n_acc;
      for (int i = 0; i < 10; i++) step();
      checks++;
      if (s_req_valid !== 1'b0) begin
         failures++;
         $display("FAIL stall_req_valid: got %b, required 0", s_req_valid);
      end
      checks++;
      if (n_acc - acc0 > BUF_DEPTH) begin
         failures++;
         $display("FAIL stall_accepts: got %0d, required at most %0d", n_acc - acc0, BUF_DEPTH);
      end
      checks++;
      if (exp_q.size() != BUF_DEPTH) begin
         failures++;
         $display("FAIL stall_fill: got %0d pending packets, required %0d", exp_q.size(), BUF_DEPTH);
      end
      ifc.fetch_ready_i = 1'b1;
      pops0 = n_pops;
      for (int i = 0; i < 10; i++) step();
      checks++;
      if (n_pops - pops0 < BUF_DEPTH) begin
         failures++;
         $display("FAIL stall_drain: got %0d packets, required at least %0d", n_pops - pops0, BUF_DEPTH);
      end
   endtask

   task automatic test_imem_stall();
      logic [31:0] held;
      ifc.imem_req_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) step();
      held = exp_pc;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (!(s_req_valid && s_req_addr == held)) begin
            failures++;
            $display("FAIL imem_stall_hold: valid=%b addr=%h, required 1 %h", s_req_valid, s_req_addr, held);
         end
      end
      ifc.imem_req_ready_i = 1'b1;
      step();
      checks++;
      if (!(s_acc && s_acc_addr == held)) begin
         failures++;
         $display("FAIL imem_stall_release: acc=%b addr=%h, required 1 %h", s_acc, s_acc_addr, held);
      end
      for (int i = 0; i < 4; i++) step();
   endtask

   task automatic test_wrap();
      logic seen;
      lat = 1;
      ifc.way1_jumpFlag_i = 1'b1;
      ifc.way1_jumpAddr_i = 32'hFFFF_FFF8;
      step();
      ifc.way1_jumpFlag_i = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step();
         if (s_acc && s_acc_addr == 32'h0000_0000) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL wrap: request 00000000 not seen, required after FFFFFFF8");
      end
   endtask

   task automatic test_back_to_back();
      logic found;
      lat = 3;
      for (int i = 0; i < 6; i++) step();
      ifc.way0_jumpFlag_i = 1'b1;
      ifc.way0_jumpAddr_i = 32'h0000_1000;
      step();
      ifc.way0_jumpFlag_i = 1'b0;
      ifc.way1_jumpFlag_i = 1'b1;
      ifc.way1_jumpAddr_i = 32'h0000_200C;
      step();
      ifc.way1_jumpFlag_i = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         step();
         found = s_acc;
      end
      checks++;
      if (!(found && s_acc_addr == 32'h0000_2008)) begin
         failures++;
         $display("FAIL b2b_req: found=%b addr=%h, required 1 00002008", found, s_acc_addr);
      end
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         step();
         found = s_pop;
      end
      checks++;
      if (!(found && !s_w0_valid && s_w1_pc == 32'h0000_200C)) begin
         failures++;
         $display("FAIL b2b_pkt: found=%b w0_valid=%b w1_pc=%h, required 1 0 0000200c", found, s_w0_valid, s_w1_pc);
      end
   endtask

   task automatic test_reset_mid();
      int pops0;
      lat = 2;
      for (int i = 0; i < 6; i++) step();
      rst = 1'b1;
      step();
      checks++;
      if ({s_req_valid, s_flush, s_fvalid, s_w1_valid} !== 4'b0 || s_req_addr !== RESET_PC) begin
         failures++;
         $display("FAIL reset_mid: ctrl=%b addr=%h, required 0000 %h", {s_req_valid, s_flush, s_fvalid, s_w1_valid}, s_req_addr, RESET_PC);
      end
      rst = 1'b0;
      step();
      checks++;
      if (!(s_acc && s_acc_addr == RESET_PC)) begin
         failures++;
         $display("FAIL reset_mid_req: acc=%b addr=%h, required 1 %h", s_acc, s_acc_addr, RESET_PC);
      end
      pops0 = n_pops;
      for (int i = 0; i < 16; i++) step();
      checks++;
      if (n_pops - pops0 < 3) begin
         failures++;
         $display("FAIL reset_mid_flow: got %0d packets, required at least 3", n_pops - pops0);
      end
   endtask

   // ---------------- main sequence and report ----------------
   initial begin
      checks = 0; failures = 0; cyc = 0; lat = 1; n_pops = 0; n_acc = 0;
      exp_pc = RESET_PC; exp_skip = 1'b0;
      rst = 1'b1;
      ifc.way0_jumpFlag_i  = 1'b0;
      ifc.way0_jumpAddr_i  = 32'd0;
      ifc.way1_jumpFlag_i  = 1'b0;
      ifc.way1_jumpAddr_i  = 32'd0;
      ifc.imem_req_ready_i = 1'b0;
      ifc.imem_rsp_valid_i = 1'b0;
      ifc.imem_rsp_data_i  = 64'd0;
      ifc.fetch_ready_i    = 1'b0;
      test_reset();
      test_sequential();
      test_redirect_drop();
      test_both_flags();
      test_stall();
      test_imem_stall();
      test_wrap();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end
endmodule
